// File: rtl/sum_uart_tx.sv
// UART 8N1 sender for the adder sum: two uppercase hex digits,
// optionally followed by CR LF, started by a synchronised button edge.
module sum_uart_tx #(
  parameter int CLKS_PER_BIT = 1042,
  parameter bit SEND_CRLF    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] sum_in,
  input  logic       send,
  output logic       tx,
  output logic       busy,
  output logic [4:0] latched_sum
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int NB = SEND_CRLF ? 4 : 2;
  localparam logic [1:0]    LAST_BYTE = 2'(NB - 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic          s1;
  logic          s2;
  logic          prev;
  logic          req;
  logic          cnt_last;
  logic [7:0]    cur_char;

  // ASCII character sent at a given byte position of the frame
  function automatic logic [7:0] char_of(
    input logic [1:0] idx,
    input logic [4:0] s
  );
    logic [7:0] nib;
    logic [7:0] c;
    nib = {4'h0, s[3:0]};
    unique case (idx)
      2'd0:    c = 8'h30 | {7'h00, s[4]};
      2'd1:    c = (s[3:0] > 4'd9) ? nib + 8'h37 : nib + 8'h30;
      2'd2:    c = 8'h0D;
      default: c = 8'h0A;
    endcase
    return c;
  endfunction

  assign req      = s2 & ~prev;
  assign cnt_last = (cnt == LAST_CNT);
  assign cur_char = char_of(byte_idx, latched_sum);

  // Two-flop synchroniser for the button plus a delay flop for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= send;
      s2   <= s1;
      prev <= s2;
    end
  end

  // Frame sequencer: start bit, 8 data bits LSB first, stop bit, per byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      latched_sum <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (req) begin
            latched_sum <= sum_in;
            busy        <= 1'b1;
            byte_idx    <= '0;
            cnt         <= '0;
            tx          <= 1'b0;
            state       <= START;
          end
        end
        START: begin
          if (cnt_last) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= cur_char[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt_last) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_char[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt_last) begin
            cnt <= '0;
            if (byte_idx == LAST_BYTE) begin
              busy  <= 1'b0;
              tx    <= 1'b1;
              state <= IDLE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              tx       <= 1'b0;
              state    <= START;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_uart_tx.sv
// Randomised bench for sum_uart_tx: decodes the serial line of a
// CR LF and a digits-only instance and compares against ASCII hex text.
module tb_sum_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] sum_in;
  logic       send_a;
  logic       send_b;
  logic       tx_a, busy_a;
  logic       tx_b, busy_b;
  logic [4:0] lat_a, lat_b;
  logic       sel;
  logic       tx_m, busy_m;
  logic [4:0] lat_m;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sum_uart_tx #(.CLKS_PER_BIT(CPB), .SEND_CRLF(1'b1)) dut_crlf (
    .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .send(send_a),
    .tx(tx_a), .busy(busy_a), .latched_sum(lat_a)
  );

  sum_uart_tx #(.CLKS_PER_BIT(CPB), .SEND_CRLF(1'b0)) dut_digits (
    .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .send(send_b),
    .tx(tx_b), .busy(busy_b), .latched_sum(lat_b)
  );

  assign tx_m   = sel ? tx_b   : tx_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign lat_m  = sel ? lat_b  : lat_a;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference text: two uppercase hex digits, then optional CR LF
  function automatic void expect_text(
    input int s, input bit crlf, output byte q[$]
  );
    int lo;
    q = {};
    lo = s % 16;
    q.push_back(byte'("0" + s / 16));
    q.push_back(lo < 10 ? byte'("0" + lo) : byte'("A" + lo - 10));
    if (crlf) begin
      q.push_back(8'h0D);
      q.push_back(8'h0A);
    end
  endfunction

  task automatic press(input bit which, input logic [4:0] s);
    sel    = which;
    sum_in = s;
    @(negedge clk);
    if (which) send_b = 1'b1;
    else       send_a = 1'b1;
  endtask

  task automatic unpress();
    @(negedge clk);
    send_a = 1'b0;
    send_b = 1'b0;
  endtask

  // Called right after press: check start latency, decode the frame
  task automatic capture(input logic [4:0] s);
    int  lat;
    int  c;
    int  nb;
    bit  bits[$];
    byte q[$];
    logic [7:0] got;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (tx_m == 1'b0) break;
    end
    chk("start_latency", lat, 3);
    c = 0;
    while (busy_m && c < 2000) begin
      if (c % CPB == CPB / 2) bits.push_back(tx_m);
      @(posedge clk); #1;
      c++;
    end
    nb = sel ? 2 : 4;
    chk("busy_cycles", c, nb * 10 * CPB);
    chk("bit_count", bits.size(), nb * 10);
    chk("latched_sum", lat_m, s);
    chk("idle_tx", tx_m, 1);
    expect_text(s, !sel, q);
    for (int b = 0; b < nb; b++) begin
      if (bits.size() >= (b + 1) * 10) begin
        for (int i = 0; i < 8; i++) got[i] = bits[b * 10 + 1 + i];
        chk($sformatf("byte%0d", b), got, q[b]);
        chk($sformatf("frame%0d", b),
            {bits[b * 10], bits[b * 10 + 9]}, 2'b01);
      end
    end
  endtask

  task automatic quiet(input int cycles, input string tag);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (busy_m || !tx_m) seen++;
    end
    chk(tag, seen, 0);
  endtask

  task automatic frame(input bit which, input logic [4:0] s);
    press(which, s);
    fork
      capture(s);
      begin
        repeat (4) @(negedge clk);
        send_a = 1'b0;
        send_b = 1'b0;
      end
    join
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int bad;
    logic [4:0] r;
    sel    = 1'b0;
    send_a = 1'b0;
    send_b = 1'b0;
    sum_in = '0;
    rst_n  = 1'b0;

    // Reset state held for 10 cycles
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (!tx_a || !tx_b || busy_a || busy_b) bad++;
    end
    chk("rst_hold", bad, 0);
    chk("rst_lat_a", lat_a, 0);
    chk("rst_lat_b", lat_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Fixed boundary frames
    frame(1'b0, 5'h1E);
    frame(1'b1, 5'h09);
    frame(1'b0, 5'h00);
    frame(1'b1, 5'h0A);

    // Random frames on both variants
    for (int k = 0; k < 8; k++) begin
      r = 5'($urandom_range(0, 30));
      frame(1'($urandom_range(0, 1)), r);
    end

    // Second edge mid-frame with new sum: dropped
    press(1'b0, 5'h15);
    fork
      capture(5'h15);
      begin
        repeat (4) @(negedge clk);
        send_a = 1'b0;
        repeat (30) @(negedge clk);
        sum_in = 5'h03;
        send_a = 1'b1;
        repeat (6) @(negedge clk);
        send_a = 1'b0;
      end
    join
    quiet(60, "no_requeue");
    chk("lat_kept", lat_a, 5'h15);

    // Reset during data bit 3
    press(1'b0, 5'h1B);
    repeat (4) @(negedge clk);
    send_a = 1'b0;
    while (tx_a && busy_a == 1'b0) @(posedge clk);
    repeat (17) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_tx", tx_a, 1);
    chk("abort_busy", busy_a, 0);
    chk("abort_lat", lat_a, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sel = 1'b0;
    quiet(50, "post_rst_idle");
    frame(1'b0, 5'h07);

    // Held button gives one frame, re-press gives another
    press(1'b1, 5'h1C);
    fork
      capture(5'h1C);
      begin
        repeat (500) @(negedge clk);
      end
    join
    quiet(300, "held_once");
    unpress();
    repeat (5) @(negedge clk);
    frame(1'b1, 5'h12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
